rb2_access_arbiter: RTL and testbench
=====================================

Name: rb2_access_arbiter

Overview:
- Shares the 8-entry x 18-bit receive register bank (RB2) between two requesters: the serial-link write requester, which delivers decoded address/data frames, and a host-side read requester.
- Issues one bank access at a time with round-robin arbitration and drives the bank's RW/A/D pins.
- Returns read data with a valid pulse.
- Tracks which entries have been written and flags completion once all 8 have been written.

Parameters:
- AW, 3, bank address width.
- DW, 18, bank data width.
- DEPTH, 8, entry count; must equal 2**AW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr_req  input  1  write request; level, held until wr_gnt.
- wr_addr  input  AW  write address; stable while wr_req is high.
- wr_data  input  DW  write data; stable while wr_req is high.
- wr_gnt  output  1  one-cycle pulse; the write is being issued this cycle.
- rd_req  input  1  read request; level, held until rd_gnt.
- rd_addr  input  AW  read address; stable while rd_req is high.
- rd_gnt  output  1  one-cycle pulse; the read is being issued this cycle.
- rd_data  output  DW  registered read data; held until the next read completes.
- rd_valid  output  1  one-cycle pulse; rd_data is updated this cycle.
- rd_written  output  1  registered with rd_data; the entry read had been written since reset.
- RB2_RW  output  1  bank mode: 1 = read, 0 = write.
- RB2_A  output  AW  bank address.
- RB2_D  output  DW  bank write data.
- RB2_Q  input  DW  bank read data; combinational from RB2_A while RB2_RW = 1.
- wr_map  output  DEPTH  bit i is set once entry i has been written.
- all_done  output  1  sticky; high once wr_map is all ones.

Behaviour:
- Reset values (on a rising edge with rst = 1, which overrides any access in flight):
  - wr_gnt = 0, rd_gnt = 0, rd_valid = 0, rd_written = 0.
  - rd_data = 0, RB2_RW = 1, RB2_A = 0, RB2_D = 0.
  - wr_map = 0, all_done = 0.
  - FSM returns to IDLE; last-served pointer = READ, so the first contended grant goes to the writer.
  - A write aborted by reset has not reached the bank, because the bank samples on the same edge with RB2_RW already forced to 1.
- FSM states: IDLE, ISSUE_WR, ISSUE_RD. All outputs are registered.
- IDLE:
  - RB2_RW = 1; wr_gnt = 0; rd_gnt = 0.
  - Sample wr_req and rd_req.
  - Neither high: stay in IDLE.
  - Only one high: go to its ISSUE state.
  - Both high: grant the requester that was not served last, then update the pointer.
- ISSUE_WR (exactly 1 cycle):
  - wr_gnt = 1, RB2_RW = 0, RB2_A = wr_addr, RB2_D = wr_data, all latched on entry.
  - The bank commits the write on the edge that ends this cycle.
  - wr_map[RB2_A] is set on the same edge.
  - Next state: IDLE.
- ISSUE_RD (exactly 1 cycle):
  - rd_gnt = 1, RB2_RW = 1, RB2_A = rd_addr.
  - On the edge that ends this cycle: rd_data <= RB2_Q and rd_written <= wr_map[RB2_A].
  - rd_valid = 1 during the following IDLE cycle.
  - Next state: IDLE.
- Latency:
  - Grant is asserted 1 cycle after the request is sampled in IDLE.
  - Read data and rd_valid follow 1 cycle after rd_gnt (2 cycles after the sampling edge).
  - Peak throughput is one access per 2 cycles.
  - Worst-case wait under continuous contention is 4 cycles.
- Handshake:
  - A requester must drop or change its request in the cycle after it sees its grant.
  - A request still high in the IDLE cycle after its grant is treated as a new request.
  - A request that drops before it is granted is ignored; nothing is issued.
- Ordering: a read and a write to the same address never overlap. A read granted after a write returns the new data.
- RB2_A and RB2_D hold their last values in IDLE; only RB2_RW returns to 1.
- all_done:
  - Set on the edge after the write that makes wr_map all ones.
  - Stays high until reset; writes continue to be serviced.
- Rewriting an already-written entry leaves wr_map unchanged.

Test Plan:
- Reset check: assert rst for 2 cycles mid-ISSUE_WR (wr_addr = 5) -> RB2_RW = 1, wr_map = 0, all_done = 0, and bank entry 5 is unchanged.
- Single write: write addr 3, data 18'h2A5A5 -> wr_gnt high in cycle t+1 with RB2_RW = 0, RB2_A = 3, RB2_D = 18'h2A5A5; wr_map = 8'b0000_1000 from t+2.
- Read-back: after writing addr 3, read addr 3 -> rd_gnt at t+1, rd_valid at t+2 with rd_data = 18'h2A5A5 and rd_written = 1. A read of unwritten addr 6 gives rd_written = 0.
- Contention: hold wr_req and rd_req continuously from reset -> grants alternate W, R, W, R at cycles 1, 3, 5, 7; no grant is ever adjacent to another.
- Completion: write addrs 0-7 (addr 2 twice) -> all_done rises exactly one cycle after the write to the final unwritten address and stays high through further writes.
- Request withdrawn: raise rd_req for 1 cycle while a write is being issued, then drop it -> no rd_gnt and no rd_valid.

Source files
------------

// File: rtl/rb2_access_if.sv
// Requester-side handshake bundle for the RB2 access arbiter: one write port
// delivering decoded link frames and one host read port.
interface rb2_access_if #(
    parameter int AW = 3,
    parameter int DW = 18
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_written;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_gnt, rd_gnt, rd_data, rd_valid, rd_written
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_gnt, rd_gnt, rd_data, rd_valid, rd_written
    );
endinterface

// File: rtl/rb2_access_arbiter.sv
// Round-robin arbiter sharing the RB2 register bank between a write and a read
// requester; issues one single-cycle access at a time and tracks written entries.
module rb2_access_arbiter #(
    parameter int AW    = 3,
    parameter int DW    = 18,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    rb2_access_if.slave      bus,
    output logic             RB2_RW,
    output logic [AW-1:0]    RB2_A,
    output logic [DW-1:0]    RB2_D,
    input  logic [DW-1:0]    RB2_Q,
    output logic [DEPTH-1:0] wr_map,
    output logic             all_done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE_WR = 2'd1,
        ST_ISSUE_RD = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic             last_rd_r, last_rd_s;
    logic             wr_gnt_r, wr_gnt_s;
    logic             rd_gnt_r, rd_gnt_s;
    logic             rw_r, rw_s;
    logic [AW-1:0]    addr_r, addr_s;
    logic [DW-1:0]    wdata_r, wdata_s;
    logic [DW-1:0]    rd_data_r;
    logic             rd_valid_r;
    logic             rd_written_r;
    logic [DEPTH-1:0] wr_map_r, wr_map_s;
    logic             all_done_r;

    function automatic logic [DEPTH-1:0] addr_onehot(input logic [AW-1:0] a);
        logic [DEPTH-1:0] v;
        v    = {DEPTH{1'b0}};
        v[a] = 1'b1;
        return v;
    endfunction

    // Next-state, grant and bank-pin decode; the writer wins a tie when the reader was served last.
    always_comb begin
        state_s   = state_r;
        last_rd_s = last_rd_r;
        wr_gnt_s  = 1'b0;
        rd_gnt_s  = 1'b0;
        rw_s      = 1'b1;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.wr_req && (!bus.rd_req || last_rd_r)) begin
                    state_s   = ST_ISSUE_WR;
                    last_rd_s = 1'b0;
                    wr_gnt_s  = 1'b1;
                    rw_s      = 1'b0;
                    addr_s    = bus.wr_addr;
                    wdata_s   = bus.wr_data;
                end else if (bus.rd_req) begin
                    state_s   = ST_ISSUE_RD;
                    last_rd_s = 1'b1;
                    rd_gnt_s  = 1'b1;
                    addr_s    = bus.rd_addr;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_ISSUE_WR: state_s = ST_IDLE;
            ST_ISSUE_RD: state_s = ST_IDLE;
            default:     state_s = ST_IDLE;
        endcase
    end

    // Written-entry map update at the end of a write issue cycle.
    always_comb begin
        wr_map_s = wr_map_r;
        if (state_r == ST_ISSUE_WR) begin
            wr_map_s = wr_map_r | addr_onehot(addr_r);
        end else begin
            wr_map_s = wr_map_r;
        end
    end

    // FSM state and registered bank/grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            last_rd_r <= 1'b1;
            wr_gnt_r  <= 1'b0;
            rd_gnt_r  <= 1'b0;
            rw_r      <= 1'b1;
            addr_r    <= {AW{1'b0}};
            wdata_r   <= {DW{1'b0}};
        end else begin
            state_r   <= state_s;
            last_rd_r <= last_rd_s;
            wr_gnt_r  <= wr_gnt_s;
            rd_gnt_r  <= rd_gnt_s;
            rw_r      <= rw_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
        end
    end

    // Read-data capture, written-entry tracking and sticky completion flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r    <= {DW{1'b0}};
            rd_valid_r   <= 1'b0;
            rd_written_r <= 1'b0;
            wr_map_r     <= {DEPTH{1'b0}};
            all_done_r   <= 1'b0;
        end else begin
            rd_valid_r <= (state_r == ST_ISSUE_RD);
            if (state_r == ST_ISSUE_RD) begin
                rd_data_r    <= RB2_Q;
                rd_written_r <= wr_map_r[addr_r];
            end
            wr_map_r   <= wr_map_s;
            all_done_r <= all_done_r | (&wr_map_s);
        end
    end

    // Reset gates the mode pin so a write in flight cannot land on the reset edge.
    assign RB2_RW         = rw_r | rst;
    assign RB2_A          = addr_r;
    assign RB2_D          = wdata_r;
    assign wr_map         = wr_map_r;
    assign all_done       = all_done_r;
    assign bus.wr_gnt     = wr_gnt_r;
    assign bus.rd_gnt     = rd_gnt_r;
    assign bus.rd_data    = rd_data_r;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.rd_written = rd_written_r;

endmodule

// File: tb/tb_rb2_access_arbiter.sv
// Directed bench for rb2_access_arbiter with a behavioural 8x18 RB2 bank model.
module tb_rb2_access_arbiter;

    logic        clk;
    logic        rst;
    logic        RB2_RW;
    logic [2:0]  RB2_A;
    logic [17:0] RB2_D;
    logic [17:0] RB2_Q;
    logic [7:0]  wr_map;
    logic        all_done;
    logic [17:0] mem [8];
    int          passed;
    int          total;

    rb2_access_if #(.AW(3), .DW(18)) bus ();

    rb2_access_arbiter #(.AW(3), .DW(18), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .RB2_RW   (RB2_RW),
        .RB2_A    (RB2_A),
        .RB2_D    (RB2_D),
        .RB2_Q    (RB2_Q),
        .wr_map   (wr_map),
        .all_done (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank: synchronous write when RW = 0, combinational read.
    always @(posedge clk) begin
        if (!RB2_RW) mem[RB2_A] <= RB2_D;
    end
    assign RB2_Q = mem[RB2_A];

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.wr_gnt !== 1'b0) $display("FAIL reset_wr_gnt got %b want 0", bus.wr_gnt); else passed++;
        total++; if (bus.rd_gnt !== 1'b0) $display("FAIL reset_rd_gnt got %b want 0", bus.rd_gnt); else passed++;
        total++; if (bus.rd_valid !== 1'b0 || bus.rd_written !== 1'b0) $display("FAIL reset_rd_flags got %b%b want 00", bus.rd_valid, bus.rd_written); else passed++;
        total++; if (bus.rd_data !== 18'h00000) $display("FAIL reset_rd_data got %h want 0", bus.rd_data); else passed++;
        total++; if (RB2_RW !== 1'b1 || RB2_A !== 3'd0 || RB2_D !== 18'h00000) $display("FAIL reset_bank_pins got %b %h %h want 1 0 0", RB2_RW, RB2_A, RB2_D); else passed++;
        total++; if (wr_map !== 8'h00 || all_done !== 1'b0) $display("FAIL reset_map got %h %b want 00 0", wr_map, all_done); else passed++;
        // Start a write to entry 5, then reset in the middle of its issue cycle.
        rst = 1'b0;
        bus.wr_req = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 18'h12345;
        @(posedge clk); #1;
        total++; if (bus.wr_gnt !== 1'b1 || RB2_RW !== 1'b0) $display("FAIL abort_issue got gnt=%b rw=%b want 1 0", bus.wr_gnt, RB2_RW); else passed++;
        rst = 1'b1; bus.wr_req = 1'b0;
        #1;
        total++; if (RB2_RW !== 1'b1) $display("FAIL abort_rw_forced got %b want 1", RB2_RW); else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++; if (mem[5] !== 18'h00105) $display("FAIL abort_bank5 got %h want 00105", mem[5]); else passed++;
        total++; if (wr_map !== 8'h00 || all_done !== 1'b0 || RB2_RW !== 1'b1) $display("FAIL abort_state got map=%h done=%b rw=%b want 00 0 1", wr_map, all_done, RB2_RW); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        @(posedge clk); #1;
        bus.wr_req = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 18'h2A5A5;
        @(posedge clk); #1;
        total++; if (bus.wr_gnt !== 1'b1) $display("FAIL sw_gnt got %b want 1", bus.wr_gnt); else passed++;
        total++; if (RB2_RW !== 1'b0 || RB2_A !== 3'd3 || RB2_D !== 18'h2A5A5) $display("FAIL sw_pins got %b %h %h want 0 3 2a5a5", RB2_RW, RB2_A, RB2_D); else passed++;
        total++; if (wr_map !== 8'h00) $display("FAIL sw_map_early got %h want 00", wr_map); else passed++;
        bus.wr_req = 1'b0;
        @(posedge clk); #1;
        total++; if (wr_map !== 8'b0000_1000) $display("FAIL sw_map got %b want 00001000", wr_map); else passed++;
        total++; if (bus.wr_gnt !== 1'b0 || RB2_RW !== 1'b1 || RB2_A !== 3'd3) $display("FAIL sw_idle got gnt=%b rw=%b a=%h want 0 1 3", bus.wr_gnt, RB2_RW, RB2_A); else passed++;
        total++; if (mem[3] !== 18'h2A5A5) $display("FAIL sw_bank3 got %h want 2a5a5", mem[3]); else passed++;
    endtask

    task automatic test_read_back();
        bus.rd_req = 1'b1; bus.rd_addr = 3'd3;
        @(posedge clk); #1;
        total++; if (bus.rd_gnt !== 1'b1 || RB2_RW !== 1'b1 || RB2_A !== 3'd3) $display("FAIL rd_issue got gnt=%b rw=%b a=%h want 1 1 3", bus.rd_gnt, RB2_RW, RB2_A); else passed++;
        total++; if (bus.rd_valid !== 1'b0) $display("FAIL rd_valid_early got %b want 0", bus.rd_valid); else passed++;
        bus.rd_req = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 18'h2A5A5 || bus.rd_written !== 1'b1) $display("FAIL rd_addr3 got v=%b d=%h w=%b want 1 2a5a5 1", bus.rd_valid, bus.rd_data, bus.rd_written); else passed++;
        bus.rd_req = 1'b1; bus.rd_addr = 3'd6;
        @(posedge clk); #1;
        total++; if (bus.rd_gnt !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_data !== 18'h2A5A5) $display("FAIL rd_hold got gnt=%b v=%b d=%h want 1 0 2a5a5", bus.rd_gnt, bus.rd_valid, bus.rd_data); else passed++;
        bus.rd_req = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 18'h00106 || bus.rd_written !== 1'b0) $display("FAIL rd_addr6 got v=%b d=%h w=%b want 1 00106 0", bus.rd_valid, bus.rd_data, bus.rd_written); else passed++;
        @(posedge clk); #1;
        total++; if (bus.rd_valid !== 1'b0) $display("FAIL rd_valid_pulse got %b want 0", bus.rd_valid); else passed++;
    endtask

    task automatic test_withdrawn();
        bus.wr_req = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 18'h0BEEF;
        @(posedge clk); #1;
        total++; if (bus.wr_gnt !== 1'b1) $display("FAIL wd_wr_gnt got %b want 1", bus.wr_gnt); else passed++;
        bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 3'd2;
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.rd_gnt !== 1'b0 || bus.rd_valid !== 1'b0) $display("FAIL wd_no_read cycle %0d got gnt=%b v=%b want 0 0", k, bus.rd_gnt, bus.rd_valid); else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        rst = 1'b1;
        bus.wr_req = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 18'h00011;
        bus.rd_req = 1'b1; bus.rd_addr = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 8) begin
                bus.wr_req = 1'b0; bus.rd_req = 1'b0;
            end
            total++; if (bus.wr_gnt !== ((k % 4) == 1) || bus.rd_gnt !== ((k % 4) == 3)) $display("FAIL cont_grant cycle %0d got w=%b r=%b want %b %b", k, bus.wr_gnt, bus.rd_gnt, ((k % 4) == 1), ((k % 4) == 3)); else passed++;
            if ((k % 4) == 0) begin
                total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 18'h00011) $display("FAIL cont_read cycle %0d got v=%b d=%h want 1 00011", k, bus.rd_valid, bus.rd_data); else passed++;
            end
        end
    endtask

    task automatic test_completion();
        logic [2:0] seq [10];
        seq = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.wr_req = 1'b1; bus.wr_addr = seq[i]; bus.wr_data = 18'h20000 | 18'(i);
            @(posedge clk); #1;
            bus.wr_req = 1'b0;
            total++; if (bus.wr_gnt !== 1'b1 || all_done !== (i >= 9)) $display("FAIL done_issue %0d got gnt=%b done=%b want 1 %b", i, bus.wr_gnt, all_done, (i >= 9)); else passed++;
            @(posedge clk); #1;
            total++; if (all_done !== (i >= 8)) $display("FAIL done_after %0d got %b want %b", i, all_done, (i >= 8)); else passed++;
        end
        total++; if (wr_map !== 8'hFF || mem[2] !== 18'h20003 || mem[0] !== 18'h20009) $display("FAIL done_final got map=%h m2=%h m0=%h want ff 20003 20009", wr_map, mem[2], mem[0]); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.wr_req = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 18'h00000;
        bus.rd_req = 1'b0; bus.rd_addr = 3'd0;
        for (int i = 0; i < 8; i++) mem[i] = 18'h00100 + 18'(i);
        test_reset();
        test_single_write();
        test_read_back();
        test_withdrawn();
        test_contention();
        test_completion();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
